// File: rtl/rr_req_frontend.sv
// Request front-end for a 4-port round-robin arbiter: per-port FIFOs, req/gnt, one registered output slot.
// Optional grant-protocol checker on err_o is enabled with `define RR_REQ_FRONTEND_CHECK_EN.
module rr_req_frontend #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_valid_i,
  input  logic [4*DW-1:0] in_data_i,
  output logic [3:0]      in_ready_o,
  output logic [3:0]      req_o,
  input  logic [3:0]      gnt_i,
  output logic            out_valid_o,
  output logic [DW-1:0]   out_data_o,
  output logic [1:0]      out_id_o,
  input  logic            out_ready_i,
  output logic            err_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wptr_q [4];
  logic [AW:0]    wptr_d [4];
  logic [AW:0]    rptr_q [4];
  logic [AW:0]    rptr_d [4];
  logic [DW-1:0]  mem_q  [4][DEPTH];

  logic [3:0]     full;
  logic [3:0]     empty;
  logic [3:0]     push;
  logic [3:0]     sel;
  logic [3:0]     pop;
  logic [1:0]     pop_id;
  logic           can_accept;

  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q,  out_data_d;
  logic [1:0]     out_id_q,    out_id_d;

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      empty[k] = (wptr_q[k] == rptr_q[k]);
      full[k]  = (wptr_q[k][AW] != rptr_q[k][AW]) &&
                 (wptr_q[k][AW-1:0] == rptr_q[k][AW-1:0]);
    end
  end

  // Ready and request depend on registered state only (plus out_ready_i for req).
  assign in_ready_o = ~full;
  assign push       = in_valid_i & in_ready_o;
  assign can_accept = !out_valid_q || out_ready_i;
  assign req_o      = ~empty & {4{can_accept}};

  // Lowest-index legal grant wins; descending scan lets lower indices overwrite.
  always_comb begin
    sel    = gnt_i & req_o;
    pop_id = '0;
    for (int unsigned k = 4; k > 0; k--) begin
      if (sel[k-1]) pop_id = 2'(k - 1);
    end
    pop         = '0;
    pop[pop_id] = |sel;
  end

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      wptr_d[k] = wptr_q[k];
      rptr_d[k] = rptr_q[k];
      if (push[k]) wptr_d[k] = wptr_q[k] + 1'b1;
      if (pop[k])  rptr_d[k] = rptr_q[k] + 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (|pop) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[pop_id][rptr_q[pop_id][AW-1:0]];
      out_id_d    = pop_id;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (push[k]) mem_q[k][wptr_q[k][AW-1:0]] <= in_data_i[k*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '{default: '0};
      rptr_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;

`ifdef RR_REQ_FRONTEND_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((gnt_i & (gnt_i - 4'd1)) != 4'd0) err_d = 1'b1;
    if ((gnt_i & ~req_o) != 4'd0)         err_d = 1'b1;
    if (gnt_i == 4'd0 && req_o != 4'd0)   err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rr_req_frontend.sv
// Directed testbench for rr_req_frontend with a behavioural round-robin arbiter closing the req/gnt loop.
module tb_rr_req_frontend;

`ifdef RR_REQ_FRONTEND_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid_i;
  logic [31:0] in_data_i;
  logic [3:0]  in_ready_o;
  logic [3:0]  req_o;
  logic [3:0]  gnt_i;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic [1:0]  out_id_o;
  logic        out_ready_i;
  logic        err_o;

  logic        use_arb;
  logic [3:0]  gnt_force;
  logic [1:0]  arb_ptr;

  int n_cmp;
  int n_fail;

  rr_req_frontend #(.DW(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_id_o    (out_id_o),
    .out_ready_i (out_ready_i),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External round-robin arbiter: search starts at arb_ptr, pointer moves past each winner.
  function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [3:0] g;
    g = 4'b0;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        g = 4'b0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  assign gnt_i = use_arb ? rr_pick(req_o, arb_ptr) : gnt_force;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_ptr <= 2'd0;
    else if (use_arb && gnt_i != 4'b0) begin
      for (int i = 0; i < 4; i++)
        if (gnt_i[i]) arb_ptr <= 2'(i + 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int port, input logic [7:0] d);
    in_data_i[port*8 +: 8] = d;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid_o); end
    n_cmp++; if (req_o !== 4'b0) begin n_fail++; $display("FAIL rst_req got %b want 0000", req_o); end
    n_cmp++; if (in_ready_o !== 4'hF) begin n_fail++; $display("FAIL rst_in_ready got %h want f", in_ready_o); end
    n_cmp++; if (out_data_o !== 8'h00 || out_id_o !== 2'd0) begin n_fail++; $display("FAIL rst_out_data got %h/%0d want 00/0", out_data_o, out_id_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err_o); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready_o !== 4'hF || req_o !== 4'b0) begin n_fail++; $display("FAIL rst_release got rdy=%h req=%b want f/0000", in_ready_o, req_o); end
  endtask

  task automatic test_single_push();
    use_arb = 1'b1; out_ready_i = 1'b1;
    in_valid_i = 4'b0010; set_word(1, 8'hA5);
    tick();
    in_valid_i = 4'b0;
    n_cmp++; if (req_o !== 4'b0010) begin n_fail++; $display("FAIL single_req got %b want 0010", req_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", out_valid_o); end
    tick();
    n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== 8'hA5 || out_id_o !== 2'd1) begin n_fail++; $display("FAIL single_out got v=%b d=%h id=%0d want 1/a5/1", out_valid_o, out_data_o, out_id_o); end
    n_cmp++; if (req_o !== 4'b0) begin n_fail++; $display("FAIL single_req_after got %b want 0000", req_o); end
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", out_valid_o); end
  endtask

  task automatic test_fill_full();
    use_arb = 1'b0; gnt_force = 4'b0; out_ready_i = 1'b0;
    in_valid_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      set_word(0, 8'h10 + 8'(i));
      tick();
    end
    n_cmp++; if (in_ready_o[0] !== 1'b0 || req_o !== 4'b0001) begin n_fail++; $display("FAIL fill_full got rdy0=%b req=%b want 0/0001", in_ready_o[0], req_o); end
    set_word(0, 8'h14);
    tick();
    n_cmp++; if (in_ready_o[0] !== 1'b0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL fill_held got rdy0=%b v=%b want 0/0", in_ready_o[0], out_valid_o); end
    use_arb = 1'b1;
    tick();
    n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h10 || out_id_o !== 2'd0) begin n_fail++; $display("FAIL fill_first_pop got v=%b d=%h id=%0d want 1/10/0", out_valid_o, out_data_o, out_id_o); end
    n_cmp++; if (req_o !== 4'b0 || in_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL fill_stall got req=%b rdy0=%b want 0000/1", req_o, in_ready_o[0]); end
    tick();
    in_valid_i = 4'b0;
    n_cmp++; if (in_ready_o[0] !== 1'b0 || out_data_o !== 8'h10) begin n_fail++; $display("FAIL fill_refull got rdy0=%b d=%h want 0/10", in_ready_o[0], out_data_o); end
    tick(); tick();
    n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h10 || req_o !== 4'b0) begin n_fail++; $display("FAIL fill_one_drain got v=%b d=%h req=%b want 1/10/0000", out_valid_o, out_data_o, req_o); end
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL fill_order[%0d] got v=%b d=%h want 1/%h", i, out_valid_o, out_data_o, 8'h10 + 8'(i)); end
    end
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b want 0", out_valid_o); end
  endtask

  task automatic test_reset_mid_burst();
    use_arb = 1'b0; gnt_force = 4'b0; out_ready_i = 1'b0;
    in_valid_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      set_word(2, 8'h20 + 8'(i));
      tick();
    end
    in_valid_i = 4'b0;
    gnt_force = 4'b0100;
    tick();
    gnt_force = 4'b0;
    n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h20 || out_id_o !== 2'd2 || req_o !== 4'b0) begin n_fail++; $display("FAIL mid_pre got v=%b d=%h id=%0d req=%b want 1/20/2/0000", out_valid_o, out_data_o, out_id_o, req_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid_o !== 1'b0 || req_o !== 4'b0 || out_data_o !== 8'h00) begin n_fail++; $display("FAIL mid_async got v=%b req=%b d=%h want 0/0000/00", out_valid_o, req_o, out_data_o); end
    tick();
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    #1;
    n_cmp++; if (in_ready_o !== 4'hF || req_o !== 4'b0) begin n_fail++; $display("FAIL mid_release got rdy=%h req=%b want f/0000", in_ready_o, req_o); end
    tick();
    n_cmp++; if (out_valid_o !== 1'b0 || req_o !== 4'b0) begin n_fail++; $display("FAIL mid_no_drain got v=%b req=%b want 0/0000", out_valid_o, req_o); end
  endtask

  task automatic test_round_robin();
    use_arb = 1'b0; gnt_force = 4'b0; out_ready_i = 1'b1;
    in_valid_i = 4'hF;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 4; k++) set_word(k, 8'(k*16 + j));
      tick();
    end
    in_valid_i = 4'b0;
    n_cmp++; if (req_o !== 4'hF) begin n_fail++; $display("FAIL rr_preload got req=%b want 1111", req_o); end
    use_arb = 1'b1;
    for (int s = 0; s < 8; s++) begin
      tick();
      n_cmp++; if (out_valid_o !== 1'b1 || out_id_o !== 2'(s % 4) || out_data_o !== 8'((s % 4)*16 + s/4)) begin
        n_fail++; $display("FAIL rr_seq[%0d] got v=%b id=%0d d=%h want 1/%0d/%h", s, out_valid_o, out_id_o, out_data_o, s % 4, 8'((s % 4)*16 + s/4));
      end
    end
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rr_done got %b want 0", out_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_id   [6] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3};
    logic [7:0] exp_data [6] = '{8'hC0, 8'hD0, 8'hD0, 8'hD0, 8'hC1, 8'hD1};
    logic       rdy_next [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    use_arb = 1'b0; gnt_force = 4'b0; out_ready_i = 1'b1;
    in_valid_i = 4'b1001;
    set_word(0, 8'hC0); set_word(3, 8'hD0);
    tick();
    set_word(0, 8'hC1); set_word(3, 8'hD1);
    tick();
    in_valid_i = 4'b0;
    use_arb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (out_valid_o !== 1'b1 || out_id_o !== exp_id[i] || out_data_o !== exp_data[i]) begin
        n_fail++; $display("FAIL bp_seq[%0d] got v=%b id=%0d d=%h want 1/%0d/%h", i, out_valid_o, out_id_o, out_data_o, exp_id[i], exp_data[i]);
      end
      if (!out_ready_i) begin
        n_cmp++; if (req_o !== 4'b0) begin n_fail++; $display("FAIL bp_req_gated[%0d] got %b want 0000", i, req_o); end
      end
      out_ready_i = rdy_next[i];
    end
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_done got %b want 0", out_valid_o); end
  endtask

  task automatic test_illegal_grant();
    use_arb = 1'b0; gnt_force = 4'b0; out_ready_i = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid_i = 4'b0101;
    set_word(0, 8'h50); set_word(2, 8'h52);
    tick();
    in_valid_i = 4'b0;
    gnt_force = 4'b0101;
    #1;
    n_cmp++; if (req_o !== 4'b0101 || err_o !== 1'b0) begin n_fail++; $display("FAIL ill_pre got req=%b err=%b want 0101/0", req_o, err_o); end
    tick();
    gnt_force = 4'b0;
    n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h50 || out_id_o !== 2'd0 || req_o !== 4'b0100) begin
      n_fail++; $display("FAIL ill_multihot got v=%b d=%h id=%0d req=%b want 1/50/0/0100", out_valid_o, out_data_o, out_id_o, req_o);
    end
    n_cmp++; if (err_o !== ERR_EN) begin n_fail++; $display("FAIL ill_err_set got %b want %b", err_o, ERR_EN); end
    tick();
    n_cmp++; if (out_valid_o !== 1'b0 || err_o !== ERR_EN) begin n_fail++; $display("FAIL ill_no_grant got v=%b err=%b want 0/%b", out_valid_o, err_o, ERR_EN); end
    gnt_force = 4'b1100;
    tick();
    n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h52 || out_id_o !== 2'd2) begin n_fail++; $display("FAIL ill_mask got v=%b d=%h id=%0d want 1/52/2", out_valid_o, out_data_o, out_id_o); end
    gnt_force = 4'b1000;
    tick();
    n_cmp++; if (out_valid_o !== 1'b0 || err_o !== ERR_EN) begin n_fail++; $display("FAIL ill_ignored got v=%b err=%b want 0/%b", out_valid_o, err_o, ERR_EN); end
    gnt_force = 4'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL ill_err_clear got %b want 0", err_o); end
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    in_valid_i = 4'b0; in_data_i = '0;
    out_ready_i = 1'b1;
    use_arb = 1'b0; gnt_force = 4'b0;
    test_reset();
    test_single_push();
    test_fill_full();
    test_reset_mid_burst();
    test_round_robin();
    test_back_to_back();
    test_illegal_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
